// File: rtl/cache_mem_arbiter_if.sv
// +----------------------------------------------------------------------+
// | cache_mem_arbiter_if: I-cache, D-cache and memory-port bus bundle     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

interface cache_mem_arbiter_if #(
  parameter int WORD_W = 8,
  parameter int ADDR_W = 32
);
  logic              i_req;
  logic              i_we;
  logic [ADDR_W-1:0] i_addr;
  logic [WORD_W-1:0] i_wdata;
  logic              i_wnext;
  logic              i_rvalid;
  logic [WORD_W-1:0] i_rdata;
  logic              i_done;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [WORD_W-1:0] d_wdata;
  logic              d_wnext;
  logic              d_rvalid;
  logic [WORD_W-1:0] d_rdata;
  logic              d_done;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [WORD_W-1:0] mem_rdata;

  modport slave (
    input  i_req, i_we, i_addr, i_wdata,
    output i_wnext, i_rvalid, i_rdata, i_done,
    input  d_req, d_we, d_addr, d_wdata,
    output d_wnext, d_rvalid, d_rdata, d_done,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport master (
    output i_req, i_we, i_addr, i_wdata,
    input  i_wnext, i_rvalid, i_rdata, i_done,
    output d_req, d_we, d_addr, d_wdata,
    input  d_wnext, d_rvalid, d_rdata, d_done,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

`default_nettype wire

// File: rtl/cache_mem_arbiter.sv
// +----------------------------------------------------------------------+
// | cache_mem_arbiter: round-robin I/D cache line bursts onto one memory |
// | port, with saturating per-cache line counters.          Rev 1.0      |
// +----------------------------------------------------------------------+
`default_nettype none

module cache_mem_arbiter #(
  parameter int WORD_W     = 8,
  parameter int ADDR_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int STAT_W     = 16
) (
  input  logic              clock,
  input  logic              reset,
  cache_mem_arbiter_if.slave bus,
  output logic [STAT_W-1:0] stat_i_lines,
  output logic [STAT_W-1:0] stat_d_lines
);
  localparam int                BEAT_W      = $clog2(LINE_WORDS);
  localparam logic [1:0]        c_IDLE      = 2'd0;
  localparam logic [1:0]        c_BURST     = 2'd1;
  localparam logic [1:0]        c_DONE      = 2'd2;
  localparam logic [BEAT_W-1:0] c_LAST_BEAT = BEAT_W'(LINE_WORDS - 1);
  localparam logic [ADDR_W-1:0] c_LINE_MASK = ADDR_W'(LINE_WORDS - 1);
  localparam logic [STAT_W-1:0] c_STAT_MAX  = '1;

  logic [1:0]        state_q,  state_d;
  logic              gnt_d_q,  gnt_d_d;   // 1 = data cache owns the burst
  logic              last_d_q, last_d_d;
  logic              we_q,     we_d;
  logic [ADDR_W-1:0] base_q,   base_d;
  logic [BEAT_W-1:0] beat_q,   beat_d;
  logic              rvalid_q, rvalid_d;
  logic              wnext_q,  wnext_d;
  logic [WORD_W-1:0] rdata_q,  rdata_d;
  logic [STAT_W-1:0] stat_i_q, stat_i_d;
  logic [STAT_W-1:0] stat_d_q, stat_d_d;

  logic w_pick_d;
  logic w_burst;
  logic w_done;

  // D wins when alone, or when both ask and I was granted last
  assign w_pick_d = bus.d_req & (~bus.i_req | ~last_d_q);

  always_comb begin
    state_d  = state_q;
    gnt_d_d  = gnt_d_q;
    last_d_d = last_d_q;
    we_d     = we_q;
    base_d   = base_q;
    beat_d   = beat_q;
    rvalid_d = 1'b0;
    wnext_d  = 1'b0;
    rdata_d  = rdata_q;
    stat_i_d = stat_i_q;
    stat_d_d = stat_d_q;
    case (state_q)
      c_IDLE: begin
        if (bus.i_req || bus.d_req) begin
          gnt_d_d  = w_pick_d;
          last_d_d = w_pick_d;
          we_d     = w_pick_d ? bus.d_we : bus.i_we;
          base_d   = (w_pick_d ? bus.d_addr : bus.i_addr) & ~c_LINE_MASK;
          beat_d   = '0;
          state_d  = c_BURST;
        end
      end
      c_BURST: begin
        if (bus.mem_ack) begin
          if (we_q) begin
            wnext_d = 1'b1;
          end else begin
            rvalid_d = 1'b1;
            rdata_d  = bus.mem_rdata;
          end
          if (beat_q == c_LAST_BEAT) begin
            state_d = c_DONE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      c_DONE: begin
        state_d = c_IDLE;
        if (gnt_d_q) begin
          if (stat_d_q != c_STAT_MAX) stat_d_d = stat_d_q + 1'b1;
        end else begin
          if (stat_i_q != c_STAT_MAX) stat_i_d = stat_i_q + 1'b1;
        end
      end
      default: state_d = c_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= c_IDLE;
      gnt_d_q  <= 1'b0;
      last_d_q <= 1'b0;
      we_q     <= 1'b0;
      base_q   <= '0;
      beat_q   <= '0;
      rvalid_q <= 1'b0;
      wnext_q  <= 1'b0;
      rdata_q  <= '0;
      stat_i_q <= '0;
      stat_d_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_d_q  <= gnt_d_d;
      last_d_q <= last_d_d;
      we_q     <= we_d;
      base_q   <= base_d;
      beat_q   <= beat_d;
      rvalid_q <= rvalid_d;
      wnext_q  <= wnext_d;
      rdata_q  <= rdata_d;
      stat_i_q <= stat_i_d;
      stat_d_q <= stat_d_d;
    end
  end

  assign w_burst = (state_q == c_BURST);
  assign w_done  = (state_q == c_DONE);

  assign bus.mem_req   = w_burst;
  assign bus.mem_we    = w_burst & we_q;
  assign bus.mem_addr  = w_burst ? (base_q | ADDR_W'(beat_q)) : '0;
  assign bus.mem_wdata = w_burst ? (gnt_d_q ? bus.d_wdata : bus.i_wdata) : '0;

  assign bus.i_rvalid = rvalid_q & ~gnt_d_q;
  assign bus.i_wnext  = wnext_q  & ~gnt_d_q;
  assign bus.i_done   = w_done   & ~gnt_d_q;
  assign bus.i_rdata  = gnt_d_q ? '0 : rdata_q;
  assign bus.d_rvalid = rvalid_q & gnt_d_q;
  assign bus.d_wnext  = wnext_q  & gnt_d_q;
  assign bus.d_done   = w_done   & gnt_d_q;
  assign bus.d_rdata  = gnt_d_q ? rdata_q : '0;

  assign stat_i_lines = stat_i_q;
  assign stat_d_lines = stat_d_q;

endmodule

`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_cache_mem_arbiter: directed self-checking bench  Rev 1.0          |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_cache_mem_arbiter;
  localparam int WORD_W     = 8;
  localparam int ADDR_W     = 32;
  localparam int LINE_WORDS = 4;
  localparam int STAT_W     = 4;   // narrow so saturation is reachable quickly

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [STAT_W-1:0] stat_i_lines;
  logic [STAT_W-1:0] stat_d_lines;
  int                checks = 0;
  int                errors = 0;
  logic [7:0]        wr_words [4];

  cache_mem_arbiter_if #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) bus ();

  cache_mem_arbiter #(
    .WORD_W(WORD_W), .ADDR_W(ADDR_W), .LINE_WORDS(LINE_WORDS), .STAT_W(STAT_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus),
    .stat_i_lines(stat_i_lines),
    .stat_d_lines(stat_d_lines)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drop_req(input bit is_d);
    if (is_d) bus.d_req = 1'b0;
    else      bus.i_req = 1'b0;
  endtask

  // Called on the first BURST cycle; returns on the DONE cycle.
  task automatic read_burst(input bit is_d, input logic [31:0] base,
                            input logic [7:0] rd0, input int drop_at);
    for (int k = 0; k < 4; k++) begin
      if (k == drop_at) drop_req(is_d);
      chk("rd_req", bus.mem_req, 1);
      chk("rd_we", bus.mem_we, 0);
      chk("rd_addr", bus.mem_addr, base + k);
      chk("rd_valid", is_d ? bus.d_rvalid : bus.i_rvalid, k > 0);
      if (k > 0) chk("rd_data", is_d ? bus.d_rdata : bus.i_rdata, 8'(rd0 + k - 1));
      chk("rd_done_early", is_d ? bus.d_done : bus.i_done, 0);
      chk("rd_other", is_d ? (bus.i_rvalid | bus.i_done) : (bus.d_rvalid | bus.d_done), 0);
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 8'(rd0 + k);
      tick;
    end
    bus.mem_ack = 1'b0;
    if (drop_at == 4) drop_req(is_d);
    chk("rd_req_drop", bus.mem_req, 0);
    chk("rd_last_valid", is_d ? bus.d_rvalid : bus.i_rvalid, 1);
    chk("rd_last_data", is_d ? bus.d_rdata : bus.i_rdata, 8'(rd0 + 3));
    chk("rd_done", is_d ? bus.d_done : bus.i_done, 1);
    chk("rd_other_done", is_d ? (bus.i_rvalid | bus.i_done) : (bus.d_rvalid | bus.d_done), 0);
  endtask

  initial begin
    wr_words = '{8'h11, 8'h22, 8'h33, 8'h44};
    bus.i_req = 0; bus.i_we = 0; bus.i_addr = '0; bus.i_wdata = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.mem_ack = 0; bus.mem_rdata = '0;

    // reset state
    tick; tick;
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_done", {bus.i_done, bus.d_done, bus.i_rvalid, bus.d_rvalid}, 0);
    chk("rst_stats", {stat_i_lines, stat_d_lines}, 0);
    reset = 1'b0;

    // single D read, base 0x10
    bus.d_req = 1; bus.d_addr = 32'h13;
    chk("d1_grant_lat", bus.mem_req, 0);
    tick;
    read_burst(1'b1, 32'h10, 8'hA0, 4);
    tick;
    chk("d1_done_once", bus.d_done, 0);
    chk("d1_stat", stat_d_lines, 1);
    chk("d1_stat_i", stat_i_lines, 0);

    // simultaneous requests after reset: D, I, D, then a fresh pair I, D
    reset = 1'b1; #1;
    chk("rst2_stat", stat_d_lines, 0);
    tick; reset = 1'b0;
    bus.i_req = 1; bus.i_addr = 32'h45; bus.d_req = 1; bus.d_addr = 32'h82;
    tick;
    read_burst(1'b1, 32'h80, 8'hB0, 5);
    tick; chk("rr_gap1", bus.mem_req, 0); tick;
    read_burst(1'b0, 32'h44, 8'hC0, 5);
    tick; chk("rr_gap2", bus.mem_req, 0); tick;
    read_burst(1'b1, 32'h80, 8'hD0, 4);
    bus.i_req = 0;
    tick;
    chk("rr_stat_d", stat_d_lines, 2);
    chk("rr_stat_i", stat_i_lines, 1);
    bus.i_req = 1; bus.d_req = 1;
    tick;
    read_burst(1'b0, 32'h44, 8'hE0, 4);
    tick; chk("rr_gap3", bus.mem_req, 0); tick;
    read_burst(1'b1, 32'h80, 8'hF0, 4);
    tick;
    chk("rr_stat_d2", stat_d_lines, 3);
    chk("rr_stat_i2", stat_i_lines, 2);

    // D write-back with 3 stall cycles per beat
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h27; bus.d_wdata = wr_words[0];
    tick;
    for (int k = 0; k < 4; k++) begin
      for (int s = 0; s < 4; s++) begin
        chk("wr_req", bus.mem_req, 1);
        chk("wr_we", bus.mem_we, 1);
        chk("wr_addr", bus.mem_addr, 32'h24 + k);
        chk("wr_wnext", bus.d_wnext, (s == 0) && (k > 0));
        chk("wr_done_early", bus.d_done, 0);
        if (s == 0 && k > 0) bus.d_wdata = wr_words[k];
        bus.mem_ack = (s == 3);
        if (s == 3) chk("wr_wdata", bus.mem_wdata, wr_words[k]);
        tick;
      end
    end
    bus.mem_ack = 0;
    chk("wr_last_wnext", bus.d_wnext, 1);
    chk("wr_done", bus.d_done, 1);
    chk("wr_req_drop", bus.mem_req, 0);
    bus.d_req = 0; bus.d_we = 0;
    tick;
    chk("wr_done_once", {bus.d_done, bus.d_wnext}, 0);
    chk("wr_stat", stat_d_lines, 4);

    // reset in the middle of an I burst
    bus.i_req = 1; bus.i_addr = 32'h53;
    tick;
    chk("mr_addr0", bus.mem_addr, 32'h50);
    bus.mem_ack = 1; bus.mem_rdata = 8'h55;
    tick;
    chk("mr_addr1", bus.mem_addr, 32'h51);
    bus.mem_rdata = 8'h66;
    tick;
    bus.mem_ack = 0;
    chk("mr_pre_valid", bus.i_rvalid, 1);
    reset = 1'b1; #1;
    chk("mr_req", bus.mem_req, 0);
    chk("mr_addr", bus.mem_addr, 0);
    chk("mr_valid", {bus.i_rvalid, bus.i_rdata, bus.i_done}, 0);
    chk("mr_stats", {stat_i_lines, stat_d_lines}, 0);
    tick;
    chk("mr_no_done", {bus.i_done, bus.mem_req}, 0);
    reset = 1'b0;
    tick;
    read_burst(1'b0, 32'h50, 8'h30, 4);
    tick;
    chk("mr_stat", stat_i_lines, 1);

    // spurious ack in IDLE, then I request dropped after beat 0
    bus.mem_ack = 1;
    tick;
    chk("sp_req", bus.mem_req, 0);
    chk("sp_valid", {bus.i_rvalid, bus.d_rvalid, bus.i_done, bus.d_done}, 0);
    tick;
    chk("sp_stat", stat_i_lines, 1);
    bus.mem_ack = 0;
    bus.i_req = 1; bus.i_addr = 32'h9E;
    tick;
    read_burst(1'b0, 32'h9C, 8'h70, 1);
    tick;
    chk("dr_done_once", bus.i_done, 0);
    chk("dr_stat", stat_i_lines, 2);
    tick;
    chk("dr_no_restart", bus.mem_req, 0);

    // counter saturation
    bus.i_req = 1; bus.i_addr = 32'h100;
    for (int n = 0; n < 20; n++) begin
      tick;
      read_burst(1'b0, 32'h100, 8'h10, 5);
      tick;
    end
    bus.i_req = 0;
    chk("sat_i", stat_i_lines, 4'hF);
    chk("sat_d", stat_d_lines, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
